// File: rtl/psum_accum_requant_pkg.sv
// Shared widths, types and arithmetic helpers for the partial-sum accumulate/requantise block.
package psum_accum_requant_pkg;

  localparam int unsigned SUM_W      = 22;
  localparam int unsigned TREE_LAT   = 5;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned SCALE_W    = 16;
  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned PROD_W  = ACC_W + SCALE_W + 1;
  // Common arithmetic width for clamp/round; must cover PROD_W plus rounding headroom.
  localparam int unsigned WIDE_W  = 64;
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;
  localparam int unsigned PEND_W  = $clog2(FIFO_DEPTH + TREE_LAT + 4);

  typedef enum logic {
    GRP_FIRST = 1'b0,
    GRP_ACCUM = 1'b1
  } grp_state_e;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } out_entry_t;

  // Clamp value to the signed range of 'width' bits; result stays sign-extended to WIDE_W.
  function automatic logic signed [WIDE_W-1:0] sat_signed(input logic signed [WIDE_W-1:0] value,
                                                          input int unsigned width);
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;
    logic signed [WIDE_W-1:0] res;
    max_v = $signed((WIDE_W'(1) << (width - 1)) - WIDE_W'(1));
    min_v = ~max_v;
    res   = value;
    if (value > max_v) begin
      res = max_v;
    end else if (value < min_v) begin
      res = min_v;
    end
    return res;
  endfunction

  // Round half up, then arithmetic right shift.
  function automatic logic signed [WIDE_W-1:0] round_shift(input logic signed [WIDE_W-1:0] value,
                                                           input int unsigned shift);
    logic signed [WIDE_W-1:0] v;
    v = value;
    if (shift != 0) begin
      v = v + $signed(WIDE_W'(1) << (shift - 1));
    end
    return v >>> shift;
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// First-word-fall-through result FIFO; exposes its fill count for the credit logic.
module psum_out_fifo
  import psum_accum_requant_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  out_entry_t       push_data,
  input  logic             pop,
  output out_entry_t       head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  out_entry_t         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               do_pop;

  assign do_pop = pop & (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/psum_accum_requant.sv
// Accumulates adder-tree sums over a group, then scales, rounds, ReLUs and saturates
// the group total into a valid/ready result FIFO under a credit scheme.
module psum_accum_requant
  import psum_accum_requant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic signed [SUM_W-1:0]   tree_sum,
  input  logic        [SCALE_W-1:0] scale,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic                      busy
);

  logic [TREE_LAT-1:0] dl_valid;
  logic [TREE_LAT-1:0] dl_last;
  logic                d_valid;
  logic                d_last;

  grp_state_e               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base, acc_new;
  logic signed [WIDE_W-1:0] acc_sum;
  logic                     acc_sat;
  logic                     grp_sat_q, grp_sat_d;
  logic                     close_grp;
  logic                     close_sat;

  logic                     m_valid;
  logic signed [ACC_W-1:0]  m_acc;
  logic                     m_sat;

  logic                     r_valid;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_sat;
  logic signed [WIDE_W-1:0] r_round;
  logic signed [WIDE_W-1:0] r_relu;
  out_entry_t               push_entry;

  out_entry_t               fifo_head;
  logic [CNT_W-1:0]         fifo_count;
  logic [PEND_W-1:0]        pending;

  // Valid/last ride alongside the tree so they line up with tree_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      dl_last  <= '0;
    end else begin
      dl_valid <= {dl_valid[TREE_LAT-2:0], in_valid};
      dl_last  <= {dl_last[TREE_LAT-2:0], in_valid & in_last};
    end
  end

  assign d_valid = dl_valid[TREE_LAT-1];
  assign d_last  = dl_last[TREE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GRP_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Group FSM plus accumulator update; the first beat of a group starts from zero.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    grp_sat_d = grp_sat_q;
    close_grp = 1'b0;
    acc_base  = acc_q;
    if (state_q == GRP_FIRST) begin
      acc_base = '0;
    end
    acc_sum   = WIDE_W'(acc_base) + WIDE_W'(tree_sum);
    acc_new   = ACC_W'(sat_signed(acc_sum, ACC_W));
    acc_sat   = (sat_signed(acc_sum, ACC_W) != acc_sum);
    close_sat = grp_sat_q | acc_sat;
    if (d_valid) begin
      if (d_last) begin
        state_d   = GRP_FIRST;
        acc_d     = '0;
        grp_sat_d = 1'b0;
        close_grp = 1'b1;
      end else begin
        state_d   = GRP_ACCUM;
        acc_d     = acc_new;
        grp_sat_d = close_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      grp_sat_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      grp_sat_q <= grp_sat_d;
    end
  end

  // Stage M captures the closed group; stage R holds the scaled product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_acc   <= '0;
      m_sat   <= 1'b0;
      r_valid <= 1'b0;
      r_prod  <= '0;
      r_sat   <= 1'b0;
    end else begin
      m_valid <= close_grp;
      if (close_grp) begin
        m_acc <= acc_new;
        m_sat <= close_sat;
      end
      r_valid <= m_valid;
      if (m_valid) begin
        r_prod <= PROD_W'(m_acc) * PROD_W'($signed({1'b0, scale}));
        r_sat  <= m_sat;
      end
    end
  end

  always_comb begin
    r_round = round_shift(WIDE_W'(r_prod), 32'(shift));
    r_relu  = r_round;
    if (relu_en && r_round[WIDE_W-1]) begin
      r_relu = '0;
    end
    push_entry.data = OUT_W'(sat_signed(r_relu, OUT_W));
    push_entry.sat  = r_sat | (sat_signed(r_relu, OUT_W) != r_relu);
  end

  psum_out_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_valid),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (fifo_head),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  assign out_data = fifo_head.data;
  assign out_sat  = fifo_head.sat;

  // Every closing beat already issued owns a future FIFO slot, including this cycle's.
  always_comb begin
    pending = PEND_W'(fifo_count) + PEND_W'(m_valid) + PEND_W'(r_valid)
            + PEND_W'(in_valid & in_last);
    for (int i = 0; i < int'(TREE_LAT); i++) begin
      pending = pending + PEND_W'(dl_last[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      in_ready <= (pending < PEND_W'(FIFO_DEPTH));
      busy     <= in_valid | (|dl_valid) | (state_q == GRP_ACCUM) | m_valid | r_valid
                | (fifo_count != '0);
    end
  end

endmodule
